// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory arbiter.
// Return FSM encoding, empty write mask, word-alignment helper.
package mem_bus_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_AUX_RD
  } arb_state_e;

  localparam logic [3:0]  WMASK_NONE = 4'b0000;
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// AUX master request/grant handshake with one-cycle read return.
// master = AUX side, slave = arbiter side.
interface mem_arbiter_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wmask, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wmask, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear dominates increment; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // count up, stop at all-ones, clear on request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU pass-through with absolute
// priority, AUX served in idle cycles, plus debug counters.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 64,
  parameter int WAIT_W       = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cpu_addr_i,
  input  logic             cpu_rstrb_i,
  input  logic [3:0]       cpu_wmask_i,
  input  logic [31:0]      cpu_wdata_i,
  output logic [31:0]      cpu_rdata_o,
  mem_arbiter_if.slave     aux,
  output logic             aux_starved_o,
  input  logic             aux_starved_clr_i,
  output logic [CNT_W-1:0] cpu_acc_cnt_o,
  output logic [CNT_W-1:0] aux_acc_cnt_o,
  output logic [31:0]      mem_addr_o,
  output logic             mem_rstrb_o,
  output logic [3:0]       mem_wmask_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam logic [WAIT_W-1:0] LIMIT =
    WAIT_W'(STARVE_LIMIT);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              cpu_busy;
  logic              gnt;
  logic              aux_rd;
  logic              wait_inc;
  logic              wait_clr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starve_set;

  assign cpu_busy = cpu_rstrb_i | (|cpu_wmask_i);
  assign gnt      = aux.req & ~cpu_busy & rst_n;
  assign aux_rd   = gnt & ~aux.we;
  assign aux.gnt  = gnt;

  assign cpu_rdata_o = mem_rdata_i;

  // memory mux: CPU fields unless AUX holds the grant
  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_rstrb_o = cpu_rstrb_i;
    mem_wmask_o = cpu_wmask_i;
    mem_wdata_o = cpu_wdata_i;
    if (gnt) begin
      mem_addr_o  = word_align(aux.addr);
      mem_rstrb_o = ~aux.we;
      mem_wmask_o = aux.we ? aux.wmask : WMASK_NONE;
      if (aux.we) begin
        mem_wdata_o = aux.wdata;
      end
    end
    if (!rst_n) begin
      mem_rstrb_o = 1'b0;
      mem_wmask_o = WMASK_NONE;
    end
  end

  // return FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // return FSM next state: any granted read lands in AUX_RD
  always_comb begin
    state_d = ST_IDLE;
    unique case (state_q)
      ST_IDLE:   if (aux_rd) state_d = ST_AUX_RD;
      ST_AUX_RD: if (aux_rd) state_d = ST_AUX_RD;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign aux.rvalid = (state_q == ST_AUX_RD);
  assign aux.rdata  = aux.rvalid ? mem_rdata_i : '0;

  assign wait_inc = aux.req & ~gnt;
  assign wait_clr = gnt | ~aux.req;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .count (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cpu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cpu_busy),
    .clr   (1'b0),
    .count (cpu_acc_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_aux_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (gnt),
    .clr   (1'b0),
    .count (aux_acc_cnt_o)
  );

  assign starve_set = (wait_cnt >= LIMIT);

  // sticky starvation flag; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aux_starved_o <= 1'b0;
    end else if (starve_set) begin
      aux_starved_o <= 1'b1;
    end else if (aux_starved_clr_i) begin
      aux_starved_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural
// synchronous RAM on the memory side.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic        cpu_rstrb;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        starved;
  logic        starved_clr;
  logic [7:0]  cpu_cnt;
  logic [7:0]  aux_cnt;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:255];

  int checks = 0;
  int errors = 0;

  mem_arbiter_if aux_if ();

  mem_arbiter #(
    .STARVE_LIMIT (4),
    .WAIT_W       (8),
    .CNT_W        (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cpu_addr_i        (cpu_addr),
    .cpu_rstrb_i       (cpu_rstrb),
    .cpu_wmask_i       (cpu_wmask),
    .cpu_wdata_i       (cpu_wdata),
    .cpu_rdata_o       (cpu_rdata),
    .aux               (aux_if),
    .aux_starved_o     (starved),
    .aux_starved_clr_i (starved_clr),
    .cpu_acc_cnt_o     (cpu_cnt),
    .aux_acc_cnt_o     (aux_cnt),
    .mem_addr_o        (mem_addr),
    .mem_rstrb_o       (mem_rstrb),
    .mem_wmask_o       (mem_wmask),
    .mem_wdata_o       (mem_wdata),
    .mem_rdata_i       (mem_rdata)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM, rdata updates on read strobe
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b])
        ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_rstrb)
      mem_rdata <= ram[mem_addr[9:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_rstrb = 1'b1;
    aux_if.req = 1'b1;
    aux_if.we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (aux_if.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b exp 0", aux_if.gnt); end
    checks++; if (mem_rstrb !== 1'b0) begin errors++; $display("FAIL rst_mem_rstrb: got %b exp 0", mem_rstrb); end
    checks++; if (mem_wmask !== 4'h0) begin errors++; $display("FAIL rst_mem_wmask: got %h exp 0", mem_wmask); end
    checks++; if (aux_if.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b exp 0", aux_if.rvalid); end
    checks++; if (aux_if.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", aux_if.rdata); end
    checks++; if (cpu_cnt !== 8'h0) begin errors++; $display("FAIL rst_cpu_cnt: got %0d exp 0", cpu_cnt); end
    checks++; if (aux_cnt !== 8'h0) begin errors++; $display("FAIL rst_aux_cnt: got %0d exp 0", aux_cnt); end
    checks++; if (starved !== 1'b0) begin errors++; $display("FAIL rst_starved: got %b exp 0", starved); end
    cpu_rstrb = 1'b0;
    aux_if.req = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_cpu_fetch();
    cpu_addr = 32'h10;
    cpu_rstrb = 1'b1;
    #1;
    checks++; if (mem_rstrb !== 1'b1) begin errors++; $display("FAIL fetch_rstrb: got %b exp 1", mem_rstrb); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr: got %h exp 10", mem_addr); end
    checks++; if (aux_if.gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt: got %b exp 0", aux_if.gnt); end
    step();
    cpu_rstrb = 1'b0;
    #1;
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h exp deadbeef", cpu_rdata); end
    checks++; if (aux_if.gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt2: got %b exp 0", aux_if.gnt); end
    checks++; if (cpu_cnt !== 8'd1) begin errors++; $display("FAIL fetch_cpu_cnt: got %0d exp 1", cpu_cnt); end
  endtask

  task automatic test_aux_write();
    aux_if.req = 1'b1;
    aux_if.we = 1'b1;
    aux_if.addr = 32'h23;
    aux_if.wmask = 4'b0011;
    aux_if.wdata = 32'h1234ABCD;
    #1;
    checks++; if (aux_if.gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b exp 1", aux_if.gnt); end
    checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL wr_addr: got %h exp 20", mem_addr); end
    checks++; if (mem_wmask !== 4'b0011) begin errors++; $display("FAIL wr_wmask: got %b exp 0011", mem_wmask); end
    checks++; if (mem_wdata !== 32'h1234ABCD) begin errors++; $display("FAIL wr_wdata: got %h exp 1234abcd", mem_wdata); end
    checks++; if (mem_rstrb !== 1'b0) begin errors++; $display("FAIL wr_rstrb: got %b exp 0", mem_rstrb); end
    step();
    aux_if.req = 1'b0;
    aux_if.we = 1'b0;
    cpu_addr = 32'h20;
    cpu_rstrb = 1'b1;
    #1;
    checks++; if (aux_if.rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid: got %b exp 0", aux_if.rvalid); end
    checks++; if (aux_cnt !== 8'd1) begin errors++; $display("FAIL wr_aux_cnt: got %0d exp 1", aux_cnt); end
    step();
    cpu_rstrb = 1'b0;
    #1;
    checks++; if (cpu_rdata !== 32'h0000ABCD) begin errors++; $display("FAIL wr_readback: got %h exp 0000abcd", cpu_rdata); end
    checks++; if (cpu_cnt !== 8'd2) begin errors++; $display("FAIL wr_cpu_cnt: got %0d exp 2", cpu_cnt); end
  endtask

  task automatic test_collision();
    cpu_addr = 32'h40;
    cpu_wmask = 4'hF;
    cpu_wdata = 32'h55AA55AA;
    aux_if.req = 1'b1;
    aux_if.we = 1'b0;
    aux_if.addr = 32'h80;
    #1;
    checks++; if (aux_if.gnt !== 1'b0) begin errors++; $display("FAIL col_gnt: got %b exp 0", aux_if.gnt); end
    checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL col_addr: got %h exp 40", mem_addr); end
    checks++; if (mem_wmask !== 4'hF) begin errors++; $display("FAIL col_wmask: got %h exp f", mem_wmask); end
    checks++; if (mem_wdata !== 32'h55AA55AA) begin errors++; $display("FAIL col_wdata: got %h exp 55aa55aa", mem_wdata); end
    step();
    cpu_wmask = 4'h0;
    #1;
    checks++; if (aux_if.gnt !== 1'b1) begin errors++; $display("FAIL col_gnt2: got %b exp 1", aux_if.gnt); end
    checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL col_addr2: got %h exp 80", mem_addr); end
    checks++; if (mem_rstrb !== 1'b1) begin errors++; $display("FAIL col_rstrb2: got %b exp 1", mem_rstrb); end
    step();
    aux_if.req = 1'b0;
    cpu_addr = 32'h10;
    cpu_rstrb = 1'b1;
    #1;
    checks++; if (aux_if.rvalid !== 1'b1) begin errors++; $display("FAIL col_rvalid: got %b exp 1", aux_if.rvalid); end
    checks++; if (aux_if.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL col_rdata: got %h exp cafef00d", aux_if.rdata); end
    step();
    cpu_rstrb = 1'b0;
    #1;
    checks++; if (aux_if.rvalid !== 1'b0) begin errors++; $display("FAIL col_rvalid_end: got %b exp 0", aux_if.rvalid); end
    checks++; if (aux_if.rdata !== 32'h0) begin errors++; $display("FAIL col_rdata_end: got %h exp 0", aux_if.rdata); end
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL col_cpu_rdata: got %h exp deadbeef", cpu_rdata); end
    checks++; if (aux_cnt !== 8'd2) begin errors++; $display("FAIL col_aux_cnt: got %0d exp 2", aux_cnt); end
    checks++; if (cpu_cnt !== 8'd4) begin errors++; $display("FAIL col_cpu_cnt: got %0d exp 4", cpu_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h11111111;
    exp_d[1] = 32'h22222222;
    exp_d[2] = 32'h33333333;
    aux_if.req = 1'b1;
    aux_if.we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      aux_if.addr = 32'(i * 4);
      #1;
      checks++; if (aux_if.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d: got %b exp 1", i, aux_if.gnt); end
      checks++; if (mem_addr !== 32'(i * 4)) begin errors++; $display("FAIL b2b_addr%0d: got %h exp %h", i, mem_addr, i * 4); end
      if (i > 0) begin
        checks++; if (aux_if.rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid%0d: got %b exp 1", i, aux_if.rvalid); end
        checks++; if (aux_if.rdata !== exp_d[i-1]) begin errors++; $display("FAIL b2b_rdata%0d: got %h exp %h", i, aux_if.rdata, exp_d[i-1]); end
      end
      step();
    end
    aux_if.req = 1'b0;
    #1;
    checks++; if (aux_if.rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid3: got %b exp 1", aux_if.rvalid); end
    checks++; if (aux_if.rdata !== exp_d[2]) begin errors++; $display("FAIL b2b_rdata3: got %h exp %h", aux_if.rdata, exp_d[2]); end
    step();
    checks++; if (aux_if.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", aux_if.rvalid); end
    checks++; if (aux_cnt !== 8'd5) begin errors++; $display("FAIL b2b_aux_cnt: got %0d exp 5", aux_cnt); end
  endtask

  task automatic test_starvation();
    cpu_addr = 32'h10;
    cpu_rstrb = 1'b1;
    aux_if.req = 1'b1;
    aux_if.we = 1'b0;
    aux_if.addr = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (aux_if.gnt !== 1'b0) begin errors++; $display("FAIL stv_gnt%0d: got %b exp 0", k, aux_if.gnt); end
      if (k == 4) begin
        checks++; if (starved !== 1'b0) begin errors++; $display("FAIL stv_early: got %b exp 0", starved); end
      end
    end
    checks++; if (starved !== 1'b1) begin errors++; $display("FAIL stv_set: got %b exp 1", starved); end
    cpu_rstrb = 1'b0;
    #1;
    checks++; if (aux_if.gnt !== 1'b1) begin errors++; $display("FAIL stv_gnt_idle: got %b exp 1", aux_if.gnt); end
    step();
    aux_if.req = 1'b0;
    #1;
    checks++; if (aux_cnt !== 8'd6) begin errors++; $display("FAIL stv_aux_cnt: got %0d exp 6", aux_cnt); end
    checks++; if (starved !== 1'b1) begin errors++; $display("FAIL stv_sticky: got %b exp 1", starved); end
    starved_clr = 1'b1;
    step();
    starved_clr = 1'b0;
    #1;
    checks++; if (starved !== 1'b0) begin errors++; $display("FAIL stv_clr: got %b exp 0", starved); end
    cpu_rstrb = 1'b1;
    aux_if.req = 1'b1;
    starved_clr = 1'b1;
    repeat (5) step();
    checks++; if (starved !== 1'b1) begin errors++; $display("FAIL stv_set_wins: got %b exp 1", starved); end
    cpu_rstrb = 1'b0;
    aux_if.req = 1'b0;
    repeat (2) step();
    starved_clr = 1'b0;
    #1;
    checks++; if (starved !== 1'b0) begin errors++; $display("FAIL stv_clr2: got %b exp 0", starved); end
    checks++; if (cpu_cnt !== 8'd14) begin errors++; $display("FAIL stv_cpu_cnt: got %0d exp 14", cpu_cnt); end
  endtask

  task automatic test_cnt_saturation();
    cpu_addr = 32'h10;
    cpu_rstrb = 1'b1;
    repeat (250) step();
    cpu_rstrb = 1'b0;
    #1;
    checks++; if (cpu_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cpu_cnt: got %0d exp 255", cpu_cnt); end
    step();
    checks++; if (cpu_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %0d exp 255", cpu_cnt); end
  endtask

  task automatic test_reset_mid_read();
    aux_if.req = 1'b1;
    aux_if.we = 1'b0;
    aux_if.addr = 32'h4;
    #1;
    checks++; if (aux_if.gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt: got %b exp 1", aux_if.gnt); end
    step();
    aux_if.req = 1'b0;
    #1;
    checks++; if (aux_if.rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid: got %b exp 1", aux_if.rvalid); end
    rst_n = 1'b0;
    cpu_rstrb = 1'b1;
    #1;
    checks++; if (aux_if.rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid_rst: got %b exp 0", aux_if.rvalid); end
    checks++; if (aux_if.rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata_rst: got %h exp 0", aux_if.rdata); end
    checks++; if (cpu_cnt !== 8'h0) begin errors++; $display("FAIL mid_cpu_cnt: got %0d exp 0", cpu_cnt); end
    checks++; if (aux_cnt !== 8'h0) begin errors++; $display("FAIL mid_aux_cnt: got %0d exp 0", aux_cnt); end
    checks++; if (mem_rstrb !== 1'b0) begin errors++; $display("FAIL mid_mem_rstrb: got %b exp 0", mem_rstrb); end
    step();
    cpu_rstrb = 1'b0;
    rst_n = 1'b1;
    step();
    checks++; if (aux_if.rvalid !== 1'b0) begin errors++; $display("FAIL mid_after: got %b exp 0", aux_if.rvalid); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0]  = 32'h11111111;
    ram[1]  = 32'h22222222;
    ram[2]  = 32'h33333333;
    ram[4]  = 32'hDEADBEEF;
    ram[32] = 32'hCAFEF00D;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    cpu_addr = 32'h0;
    cpu_rstrb = 1'b0;
    cpu_wmask = 4'h0;
    cpu_wdata = 32'h0;
    starved_clr = 1'b0;
    aux_if.req = 1'b0;
    aux_if.we = 1'b0;
    aux_if.addr = 32'h0;
    aux_if.wmask = 4'h0;
    aux_if.wdata = 32'h0;
    test_reset();
    test_cpu_fetch();
    test_aux_write();
    test_collision();
    test_back_to_back();
    test_starvation();
    test_cnt_saturation();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between two masters: the processor's memory port (CPU) and an auxiliary master (AUX: program loader / debug DMA).
- The CPU port has no stall signal and always has absolute priority. Its accesses pass straight through with zero added latency.
- AUX gets the memory only in cycles where the CPU is not accessing it, using a req/gnt handshake and a one-cycle read-data return.
- Sits between processor and RAM at SoC top level. It also provides starvation monitoring and access counters for debug.

Parameters:
- STARVE_LIMIT, 64, number of consecutive ungranted AUX request cycles after which aux_starved_o asserts.
- WAIT_W, 8, width of the AUX wait counter. Must satisfy 2^WAIT_W > STARVE_LIMIT.
- CNT_W, 16, width of the saturating access counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr_i  in  32  CPU byte address (word aligned for data, PC for fetch).
- cpu_rstrb_i  in  1  CPU read strobe.
- cpu_wmask_i  in  4  CPU byte write enables.
- cpu_wdata_i  in  32  CPU write data.
- cpu_rdata_o  out  32  read data to CPU.
- aux_req_i  in  1  AUX request. Held with addr/we/wmask/wdata stable until granted.
- aux_we_i  in  1  1 = write, 0 = read.
- aux_addr_i  in  32  AUX word address (bits [1:0] ignored, forced to 0 on the memory bus).
- aux_wmask_i  in  4  AUX byte enables (write only).
- aux_wdata_i  in  32  AUX write data.
- aux_gnt_o  out  1  transfer accepted this cycle.
- aux_rvalid_o  out  1  AUX read data valid.
- aux_rdata_o  out  32  AUX read data.
- aux_starved_o  out  1  sticky starvation flag.
- aux_starved_clr_i  in  1  clears aux_starved_o.
- cpu_acc_cnt_o  out  CNT_W  saturating count of CPU access cycles.
- aux_acc_cnt_o  out  CNT_W  saturating count of AUX grants.
- mem_addr_o  out  32  memory address.
- mem_rstrb_o  out  1  memory read strobe.
- mem_wmask_o  out  4  memory byte write enables.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_rstrb_o.

Behaviour:
- cpu_busy = cpu_rstrb_i | (|cpu_wmask_i).
- aux_gnt_o = aux_req_i & ~cpu_busy & rst_n. This is combinational, same cycle.
- Memory mux, combinational:
  - If cpu_busy or ~aux_gnt_o, the memory sees the CPU fields unchanged (mem_addr_o = cpu_addr_i even when idle).
  - If aux_gnt_o, mem_addr_o = {aux_addr_i[31:2], 2'b00}.
  - AUX read: mem_rstrb_o = 1, mem_wmask_o = 0.
  - AUX write: mem_rstrb_o = 0, mem_wmask_o = aux_wmask_i, mem_wdata_o = aux_wdata_i.
- While rst_n = 0, mem_rstrb_o = 0 and mem_wmask_o = 0.
- cpu_rdata_o = mem_rdata_i always (pass-through). The CPU never observes added latency.
- Return FSM, states IDLE and AUX_RD:
  - IDLE -> AUX_RD on a granted AUX read.
  - AUX_RD -> AUX_RD on another granted AUX read (back-to-back reads allowed).
  - AUX_RD -> IDLE otherwise.
- aux_rvalid_o = (state == AUX_RD). While it is high, aux_rdata_o = mem_rdata_i; otherwise aux_rdata_o = 0.
- AUX writes produce no rvalid.
- A CPU access in the cycle after an AUX read is legal. aux_rdata_o still reflects the AUX read because memory updates rdata only at the next edge.
- Wait counter:
  - Increments each cycle aux_req_i & ~aux_gnt_o, saturating at all-ones.
  - Clears on aux_gnt_o or ~aux_req_i.
- aux_starved_o sets when the wait counter reaches STARVE_LIMIT. It stays set until aux_starved_clr_i; a set in the same cycle as a clear wins.
- Access counters:
  - cpu_acc_cnt_o increments each cycle cpu_busy.
  - aux_acc_cnt_o increments each cycle aux_gnt_o.
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, active-low): state = IDLE, aux_rvalid_o = 0, aux_rdata_o = 0, wait counter = 0, aux_starved_o = 0, both access counters = 0.
  - Reset asserted mid-AUX-read drops rvalid immediately; the read is lost and AUX must reissue.
- aux_req_i deasserted without a grant: legal, no side effect, wait counter cleared.

Decomposition:
- Shared package mem_bus_pkg: state encoding (ST_IDLE, ST_AUX_RD), WMASK_NONE = 4'b0000, helper constant for word alignment.
- One natural sub-module, sat_counter (parameter width; inputs inc/clr; output count). It is instantiated three times: wait, CPU, AUX counters.

Test Plan:
- CPU-only fetch: cpu_rstrb_i = 1, cpu_addr_i = 0x10, RAM[0x10] = 0xDEADBEEF -> mem_rstrb_o = 1 and mem_addr_o = 0x10 the same cycle; cpu_rdata_o = 0xDEADBEEF the next cycle; aux_gnt_o = 0 throughout.
- AUX write in idle gap: aux_req_i = 1, we = 1, addr = 0x23, wmask = 4'b0011, wdata = 0x1234ABCD, CPU idle -> aux_gnt_o = 1, mem_addr_o = 0x20, mem_wmask_o = 4'b0011; a later read of 0x20 returns low half 0xABCD.
- Collision: CPU store (wmask = 4'b1111, addr 0x40) while an AUX read of 0x80 is pending -> CPU fields on bus, aux_gnt_o = 0. The next idle cycle grants AUX; aux_rvalid_o = 1 one cycle later with RAM[0x80].
- Back-to-back AUX reads of 0x0, 0x4, 0x8 with CPU idle -> three consecutive grants; rvalid high 3 cycles with the data in order; FSM stays in AUX_RD.
- Starvation: STARVE_LIMIT = 4, cpu_rstrb_i held high, aux_req_i high -> aux_starved_o rises after 4 waiting cycles and stays set after CPU idles. aux_starved_clr_i clears it. aux_acc_cnt_o = 1 after the eventual grant.
- Reset mid-read: AUX read granted, rst_n pulsed low before the next edge -> aux_rvalid_o = 0 immediately; all counters = 0; mem_rstrb_o = 0 during reset.
